// File: rtl/alu_serial_rx_pkg.sv
// alu_pkg: opcodes, frame constants, output bundle and CRC4 reference for the serial ALU input stage
package alu_pkg;
    typedef enum logic [2:0] {
        and_op = 3'b000,
        or_op  = 3'b001,
        add_op = 3'b100,
        sub_op = 3'b101
    } operation_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        valid;
        logic        err_data;
        logic        err_crc;
        logic        err_op;
        logic        err_frame;
    } rx_out_t;

    localparam logic       FRAME_DATA = 1'b0;
    localparam logic       FRAME_CMD  = 1'b1;
    localparam logic [3:0] CRC4_POLY  = 4'b0011;

    function automatic logic [3:0] calc_crc4(input bit [67:0] d);
        logic [3:0] c;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) c = {c[2:0], 1'b0} ^ ((d[i] ^ c[3]) ? CRC4_POLY : 4'b0000);
        return c;
    endfunction
endpackage

// File: rtl/alu_serial_rx_if.sv
// alu_serial_rx_if: serial input line plus the registered packet presented to the ALU core
interface alu_serial_rx_if;
    logic        sin;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        valid;
    logic        err_data;
    logic        err_crc;
    logic        err_op;
    logic        err_frame;

    modport master (output sin, input A, B, op, valid, err_data, err_crc, err_op, err_frame);
    modport slave  (input sin, output A, B, op, valid, err_data, err_crc, err_op, err_frame);
endinterface

// File: rtl/alu_serial_rx_crc4.sv
// alu_crc4_serial: bit-serial CRC4 (x^4+x+1) with synchronous clear
module alu_crc4_serial
    import alu_pkg::*;
#(
    parameter logic [3:0] CRC_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [3:0] crc_o
);
    logic [3:0] crc_q, crc_d;

    always_comb crc_d = clear_i ? CRC_INIT
                      : en_i    ? {crc_q[2:0], 1'b0} ^ ((din_i ^ crc_q[3]) ? CRC4_POLY : 4'b0000)
                      : crc_q;

    always_ff @(posedge clk) crc_q <= rst ? CRC_INIT : crc_d;

    assign crc_o = crc_q;
endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises data/command frames into B, A, op and flags sequence, framing, CRC and opcode errors
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int         DATA_BYTES = 8,
    parameter logic [3:0] CRC_INIT   = 4'b0000
) (
    input logic            clk,
    input logic            rst,
    alu_serial_rx_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, TYPE = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        type_q, type_d;
    logic [6:0]  byte_q, byte_d;
    logic [63:0] sr_q, sr_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    rx_out_t     out_q, out_d;
    logic [3:0]  crc;
    logic        stop_ok, stop_bad, cmd_done, bad_len, bad_crc, bad_op, crc_en, crc_din;

    assign stop_ok  = state_q == STOP && bus.sin;
    assign stop_bad = state_q == STOP && !bus.sin;
    assign cmd_done = stop_ok && type_q == FRAME_CMD;
    assign bad_len  = byte_cnt_q != 4'(DATA_BYTES);
    assign bad_crc  = byte_q[3:0] != crc;
    assign bad_op   = !(byte_q[6:4] inside {and_op, or_op, add_op, sub_op});

    // Command frames feed the CRC an injected 1 in place of the reserved bit, then the op bits
    assign crc_en  = state_q == DATA && (type_q == FRAME_DATA || bit_cnt_q >= 3'd4);
    assign crc_din = type_q == FRAME_CMD && bit_cnt_q == 3'd7 ? 1'b1 : bus.sin;

    alu_crc4_serial #(.CRC_INIT(CRC_INIT)) u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear_i(stop_bad || cmd_done),
        .en_i   (crc_en),
        .din_i  (crc_din),
        .crc_o  (crc)
    );

    always_comb begin
        state_d    = state_q == IDLE ? (bus.sin ? IDLE : TYPE)
                   : state_q == TYPE ? DATA
                   : state_q == DATA ? (bit_cnt_q == 3'd0 ? STOP : DATA)
                   : IDLE;
        bit_cnt_d  = state_q == DATA ? bit_cnt_q - 3'd1 : 3'd7;
        type_d     = state_q == TYPE ? bus.sin : type_q;
        byte_d     = state_q == DATA ? {byte_q[5:0], bus.sin} : byte_q;
        sr_d       = state_q == DATA && type_q == FRAME_DATA ? {sr_q[62:0], bus.sin} : sr_q;
        byte_cnt_d = stop_bad || cmd_done ? 4'd0
                   : stop_ok && byte_cnt_q != 4'(DATA_BYTES + 1) ? byte_cnt_q + 4'd1
                   : byte_cnt_q;
    end

    always_comb begin
        out_d           = out_q;
        out_d.valid     = cmd_done;
        out_d.err_frame = stop_bad;
        if (cmd_done) begin
            out_d.op       = byte_q[6:4];
            out_d.err_data = bad_len;
            out_d.err_crc  = !bad_len && bad_crc;
            out_d.err_op   = !bad_len && !bad_crc && bad_op;
            if (!bad_len) {out_d.b, out_d.a} = sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd7;
            type_q     <= FRAME_DATA;
            byte_q     <= '0;
            sr_q       <= '0;
            byte_cnt_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            type_q     <= type_d;
            byte_q     <= byte_d;
            sr_q       <= sr_d;
            byte_cnt_q <= byte_cnt_d;
            out_q      <= out_d;
        end
    end

    assign bus.A         = out_q.a;
    assign bus.B         = out_q.b;
    assign bus.op        = out_q.op;
    assign bus.valid     = out_q.valid;
    assign bus.err_data  = out_q.err_data;
    assign bus.err_crc   = out_q.err_crc;
    assign bus.err_op    = out_q.err_op;
    assign bus.err_frame = out_q.err_frame;
endmodule
